// File: rtl/l1d_mshr_file.sv
// -----------------------------------------------------------------------------
// l1d_mshr_file
//   State file for the L1D miss status holding registers. Every entry runs
//   through FREE -> RSVD -> REQ -> WAIT -> DONE -> FREE and keeps the line
//   address of the miss it serves.
//
//   v_free_vld      out  per-entry FREE flag offered to the pre-allocator
//   v_free_rdy      in   per-entry reservation (one-hot or multi-hot)
//   alloc_id_vld/alloc_id/alloc_id_rdy
//                        pre-allocated ID, consumed when a primary miss is taken
//   miss_vld/miss_line_addr/miss_rdy/miss_mshr_id
//                        primary miss request and the entry it was given
//   mem_req_vld/rdy/id/addr
//                        line fetch to memory, lowest-index REQ entry first
//   mem_resp_vld/id      fill response, always accepted, may be out of order
//   refill_vld/rdy/id/addr
//                        completed entry handed to the refill datapath
//   mshr_busy_num        registered count of non-FREE entries
// -----------------------------------------------------------------------------
module l1d_mshr_file #(
  parameter int L1D_MSHR_ENTRY_NUM = 4,
  parameter int L1D_MSHR_ID_WIDTH  = 2,
  parameter int LINE_ADDR_WIDTH    = 26
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [L1D_MSHR_ENTRY_NUM-1:0] v_free_vld,
  input  logic [L1D_MSHR_ENTRY_NUM-1:0] v_free_rdy,
  input  logic                          alloc_id_vld,
  input  logic [L1D_MSHR_ID_WIDTH-1:0]  alloc_id,
  output logic                          alloc_id_rdy,
  input  logic                          miss_vld,
  input  logic [LINE_ADDR_WIDTH-1:0]    miss_line_addr,
  output logic                          miss_rdy,
  output logic [L1D_MSHR_ID_WIDTH-1:0]  miss_mshr_id,
  output logic                          mem_req_vld,
  input  logic                          mem_req_rdy,
  output logic [L1D_MSHR_ID_WIDTH-1:0]  mem_req_id,
  output logic [LINE_ADDR_WIDTH-1:0]    mem_req_addr,
  input  logic                          mem_resp_vld,
  input  logic [L1D_MSHR_ID_WIDTH-1:0]  mem_resp_id,
  output logic                          refill_vld,
  input  logic                          refill_rdy,
  output logic [L1D_MSHR_ID_WIDTH-1:0]  refill_id,
  output logic [LINE_ADDR_WIDTH-1:0]    refill_addr,
  output logic [L1D_MSHR_ID_WIDTH:0]    mshr_busy_num
);

  localparam int NUM   = L1D_MSHR_ENTRY_NUM;
  localparam int ID_W  = L1D_MSHR_ID_WIDTH;
  localparam int CNT_W = L1D_MSHR_ID_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_FREE = 3'd0,
    ST_RSVD = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } ent_state_e;

  ent_state_e                 state_q   [NUM];
  ent_state_e                 state_nxt [NUM];
  logic [LINE_ADDR_WIDTH-1:0] addr_q    [NUM];
  logic [CNT_W-1:0]           busy_nxt;

  // Once a request is shown without being taken, its ID is frozen so a
  // lower-index entry entering REQ cannot swap the payload under the handshake.
  logic                       req_lock_q;
  logic [ID_W-1:0]            req_lock_id_q;

  logic                       req_any;
  logic [ID_W-1:0]            req_low;
  logic                       done_any;
  logic [ID_W-1:0]            done_low;
  logic                       match;
  logic                       miss_fire;

  always_comb begin
    v_free_vld = '0;
    for (int i = 0; i < NUM; i++) begin
      v_free_vld[i] = (state_q[i] == ST_FREE);
    end
  end

  // A miss to a line already being fetched (or waiting for refill) must stall.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (miss_vld && (state_q[i] inside {ST_REQ, ST_WAIT, ST_DONE}) &&
          (addr_q[i] == miss_line_addr)) begin
        match = 1'b1;
      end
    end
  end

  assign miss_rdy     = alloc_id_vld && !match;
  assign alloc_id_rdy = miss_vld && !match;
  assign miss_mshr_id = alloc_id;
  assign miss_fire    = miss_vld && alloc_id_vld && !match;

  // Lowest-index search: scanning downward leaves the smallest hit last.
  always_comb begin
    req_any  = 1'b0;
    req_low  = '0;
    done_any = 1'b0;
    done_low = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (state_q[i] == ST_REQ) begin
        req_any = 1'b1;
        req_low = ID_W'(i);
      end
      if (state_q[i] == ST_DONE) begin
        done_any = 1'b1;
        done_low = ID_W'(i);
      end
    end
  end

  assign mem_req_vld  = req_any;
  assign mem_req_id   = req_lock_q ? req_lock_id_q : req_low;
  assign mem_req_addr = addr_q[mem_req_id];
  assign refill_vld   = done_any;
  assign refill_id    = done_low;
  assign refill_addr  = addr_q[done_low];

  // Each state has exactly one exit condition, so no entry can take two
  // transitions in one cycle while different entries advance independently.
  always_comb begin
    busy_nxt = '0;
    for (int i = 0; i < NUM; i++) begin
      state_nxt[i] = state_q[i];
      case (state_q[i])
        ST_FREE: if (v_free_rdy[i]) state_nxt[i] = ST_RSVD;
        ST_RSVD: if (miss_fire && (alloc_id == ID_W'(i))) state_nxt[i] = ST_REQ;
        ST_REQ:  if (mem_req_vld && mem_req_rdy && (mem_req_id == ID_W'(i)))
                   state_nxt[i] = ST_WAIT;
        ST_WAIT: if (mem_resp_vld && (mem_resp_id == ID_W'(i))) state_nxt[i] = ST_DONE;
        ST_DONE: if (refill_vld && refill_rdy && (refill_id == ID_W'(i)))
                   state_nxt[i] = ST_FREE;
        default: state_nxt[i] = ST_FREE;
      endcase
      if (state_nxt[i] != ST_FREE) busy_nxt = busy_nxt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) begin
        state_q[i] <= ST_FREE;
        addr_q[i]  <= '0;
      end
      mshr_busy_num <= '0;
      req_lock_q    <= 1'b0;
      req_lock_id_q <= '0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        state_q[i] <= state_nxt[i];
        if ((state_q[i] == ST_RSVD) && miss_fire && (alloc_id == ID_W'(i))) begin
          addr_q[i] <= miss_line_addr;
        end
      end
      mshr_busy_num <= busy_nxt;
      req_lock_q    <= mem_req_vld && !mem_req_rdy;
      req_lock_id_q <= mem_req_id;
    end
  end

endmodule

// File: tb/tb_l1d_mshr_file.sv
// -----------------------------------------------------------------------------
// tb_l1d_mshr_file
//   Directed bench for l1d_mshr_file. A per-entry life-cycle model tracks what
//   every entry must be doing and a negedge process compares all DUT outputs
//   against it each cycle; directed steps add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_l1d_mshr_file;

  localparam int NUM = 4;
  localparam int ID_W = 2;
  localparam int LW = 26;

  localparam int FREE = 0, RSVD = 1, REQ = 2, WAIT = 3, DONE = 4;

  logic            clk;
  logic            rst;
  logic [NUM-1:0]  v_free_vld;
  logic [NUM-1:0]  v_free_rdy;
  logic            alloc_id_vld;
  logic [ID_W-1:0] alloc_id;
  logic            alloc_id_rdy;
  logic            miss_vld;
  logic [LW-1:0]   miss_line_addr;
  logic            miss_rdy;
  logic [ID_W-1:0] miss_mshr_id;
  logic            mem_req_vld;
  logic            mem_req_rdy;
  logic [ID_W-1:0] mem_req_id;
  logic [LW-1:0]   mem_req_addr;
  logic            mem_resp_vld;
  logic [ID_W-1:0] mem_resp_id;
  logic            refill_vld;
  logic            refill_rdy;
  logic [ID_W-1:0] refill_id;
  logic [LW-1:0]   refill_addr;
  logic [ID_W:0]   mshr_busy_num;

  l1d_mshr_file dut (
    .clk(clk), .rst(rst),
    .v_free_vld(v_free_vld), .v_free_rdy(v_free_rdy),
    .alloc_id_vld(alloc_id_vld), .alloc_id(alloc_id), .alloc_id_rdy(alloc_id_rdy),
    .miss_vld(miss_vld), .miss_line_addr(miss_line_addr), .miss_rdy(miss_rdy),
    .miss_mshr_id(miss_mshr_id),
    .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_id(mem_req_id),
    .mem_req_addr(mem_req_addr),
    .mem_resp_vld(mem_resp_vld), .mem_resp_id(mem_resp_id),
    .refill_vld(refill_vld), .refill_rdy(refill_rdy), .refill_id(refill_id),
    .refill_addr(refill_addr),
    .mshr_busy_num(mshr_busy_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Model: life-cycle stage and line address of every entry, plus the
  // frozen request ID while memory back-pressures.
  int            m_stage [NUM];
  logic [LW-1:0] m_addr  [NUM];
  bit            m_lock;
  int            m_lock_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_in(input int st);
    for (int i = 0; i < NUM; i++) if (m_stage[i] == st) return i;
    return -1;
  endfunction

  function automatic bit line_inflight(input logic [LW-1:0] a);
    for (int i = 0; i < NUM; i++)
      if (m_stage[i] >= REQ && m_addr[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int busy_count();
    int c = 0;
    for (int i = 0; i < NUM; i++) if (m_stage[i] != FREE) c++;
    return c;
  endfunction

  function automatic int exp_req_id();
    return m_lock ? m_lock_id : lowest_in(REQ);
  endfunction

  task automatic model_step();
    int old [NUM];
    int rq, rf;
    bit hit;
    if (rst) begin
      for (int i = 0; i < NUM; i++) begin
        m_stage[i] = FREE;
        m_addr[i]  = '0;
      end
      m_lock = 0;
      m_lock_id = 0;
      return;
    end
    for (int i = 0; i < NUM; i++) old[i] = m_stage[i];
    rq  = exp_req_id();
    rf  = lowest_in(DONE);
    hit = miss_vld && line_inflight(miss_line_addr);
    for (int i = 0; i < NUM; i++)
      if (old[i] == FREE && v_free_rdy[i]) m_stage[i] = RSVD;
    if (miss_vld && alloc_id_vld && !hit) begin
      assert (old[alloc_id] == RSVD) else $error("stimulus: alloc_id %0d not reserved", alloc_id);
      if (old[alloc_id] == RSVD) begin
        m_stage[alloc_id] = REQ;
        m_addr[alloc_id]  = miss_line_addr;
      end
    end
    if (rq >= 0 && mem_req_rdy) m_stage[rq] = WAIT;
    if (mem_resp_vld && old[mem_resp_id] == WAIT) m_stage[mem_resp_id] = DONE;
    if (rf >= 0 && refill_rdy) m_stage[rf] = FREE;
    m_lock    = (rq >= 0) && !mem_req_rdy;
    m_lock_id = (rq >= 0) ? rq : 0;
  endtask

  initial begin
    for (int i = 0; i < NUM; i++) begin
      m_stage[i] = FREE;
      m_addr[i]  = '0;
    end
    m_lock = 0;
    m_lock_id = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    logic [NUM-1:0] ef;
    bit hit;
    int rq, rf;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        ef = '0;
        for (int i = 0; i < NUM; i++) ef[i] = (m_stage[i] == FREE);
        hit = miss_vld && line_inflight(miss_line_addr);
        rq  = exp_req_id();
        rf  = lowest_in(DONE);
        check("v_free_vld", 32'(v_free_vld), 32'(ef));
        check("miss_rdy", 32'(miss_rdy), 32'(alloc_id_vld && !hit));
        check("alloc_id_rdy", 32'(alloc_id_rdy), 32'(miss_vld && !hit));
        if (miss_vld && miss_rdy) check("miss_mshr_id", 32'(miss_mshr_id), 32'(alloc_id));
        check("mem_req_vld", 32'(mem_req_vld), 32'(rq >= 0));
        if (rq >= 0) begin
          check("mem_req_id", 32'(mem_req_id), 32'(rq));
          check("mem_req_addr", 32'(mem_req_addr), 32'(m_addr[rq]));
        end
        check("refill_vld", 32'(refill_vld), 32'(rf >= 0));
        if (rf >= 0) begin
          check("refill_id", 32'(refill_id), 32'(rf));
          check("refill_addr", 32'(refill_addr), 32'(m_addr[rf]));
        end
        check("mshr_busy_num", 32'(mshr_busy_num), 32'(busy_count()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic miss(input logic [ID_W-1:0] id, input logic [LW-1:0] a);
    miss_vld = 1'b1; alloc_id_vld = 1'b1; alloc_id = id; miss_line_addr = a;
  endtask

  task automatic no_miss();
    miss_vld = 1'b0; alloc_id_vld = 1'b0;
  endtask

  int got_ids [$];
  int order [4] = '{2, 0, 3, 1};

  initial begin
    rst = 1'b1;
    v_free_rdy = '0; alloc_id_vld = 1'b0; alloc_id = '0;
    miss_vld = 1'b0; miss_line_addr = '0; mem_req_rdy = 1'b0;
    mem_resp_vld = 1'b0; mem_resp_id = '0; refill_rdy = 1'b0;

    // 1. reset and idle
    repeat (2) cyc();
    chk_en = 1;
    rst = 1'b0;
    repeat (2) cyc();
    check("t1 v_free_vld", 32'(v_free_vld), 32'h0000000f);
    check("t1 mem_req_vld", 32'(mem_req_vld), 32'd0);
    check("t1 refill_vld", 32'(refill_vld), 32'd0);
    check("t1 busy", 32'(mshr_busy_num), 32'd0);

    // 2. basic flow on entry 0
    v_free_rdy = 4'b0001; cyc(); v_free_rdy = '0;
    check("t2 v_free_vld rsvd", 32'(v_free_vld), 32'h0000000e);
    check("t2 busy rsvd", 32'(mshr_busy_num), 32'd1);
    miss(2'd0, 26'h100); #1;
    check("t2 miss_rdy", 32'(miss_rdy), 32'd1);
    check("t2 miss_mshr_id", 32'(miss_mshr_id), 32'd0);
    cyc(); no_miss();
    check("t2 mem_req_vld", 32'(mem_req_vld), 32'd1);
    check("t2 mem_req_id", 32'(mem_req_id), 32'd0);
    check("t2 mem_req_addr", 32'(mem_req_addr), 32'h100);
    mem_req_rdy = 1'b1; cyc(); mem_req_rdy = 1'b0;
    check("t2 mem_req_vld wait", 32'(mem_req_vld), 32'd0);
    mem_resp_vld = 1'b1; mem_resp_id = 2'd0; cyc(); mem_resp_vld = 1'b0;
    check("t2 refill_vld", 32'(refill_vld), 32'd1);
    check("t2 refill_id", 32'(refill_id), 32'd0);
    refill_rdy = 1'b1; cyc(); refill_rdy = 1'b0;
    check("t2 v_free_vld after refill", 32'(v_free_vld), 32'h0000000f);
    check("t2 busy after refill", 32'(mshr_busy_num), 32'd0);

    // 3. secondary miss stall on entry 1's line
    v_free_rdy = 4'b0010; cyc(); v_free_rdy = '0;
    miss(2'd1, 26'h200); cyc(); no_miss();
    mem_req_rdy = 1'b1; cyc(); mem_req_rdy = 1'b0;
    v_free_rdy = 4'b0100; cyc(); v_free_rdy = '0;
    miss(2'd2, 26'h200); #1;
    check("t3 miss_rdy stall", 32'(miss_rdy), 32'd0);
    check("t3 alloc_id_rdy stall", 32'(alloc_id_rdy), 32'd0);
    repeat (3) cyc();
    check("t3 miss_rdy still stalled", 32'(miss_rdy), 32'd0);
    mem_resp_vld = 1'b1; mem_resp_id = 2'd1; cyc(); mem_resp_vld = 1'b0; #1;
    check("t3 miss_rdy stall in done", 32'(miss_rdy), 32'd0);
    refill_rdy = 1'b1; cyc(); refill_rdy = 1'b0; #1;
    check("t3 miss_rdy released", 32'(miss_rdy), 32'd1);
    check("t3 alloc_id_rdy released", 32'(alloc_id_rdy), 32'd1);
    cyc(); no_miss();
    check("t3 mem_req_id", 32'(mem_req_id), 32'd2);
    mem_req_rdy = 1'b1; cyc(); mem_req_rdy = 1'b0;
    mem_resp_vld = 1'b1; mem_resp_id = 2'd2; cyc(); mem_resp_vld = 1'b0;
    refill_rdy = 1'b1; cyc(); refill_rdy = 1'b0;

    // 4. full file, out-of-order responses
    v_free_rdy = 4'b1111; cyc(); v_free_rdy = '0;
    check("t4 v_free_vld full", 32'(v_free_vld), 32'd0);
    check("t4 busy full", 32'(mshr_busy_num), 32'd4);
    mem_req_rdy = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      miss(ID_W'(i), 26'h300 + LW'(i * 16));
      cyc();
    end
    no_miss(); cyc(); mem_req_rdy = 1'b0;
    check("t4 all waiting", 32'(mem_req_vld), 32'd0);
    check("t4 busy waiting", 32'(mshr_busy_num), 32'd4);
    refill_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mem_resp_vld = (k < 4);
      mem_resp_id  = (k < 4) ? ID_W'(order[k]) : '0;
      #1;
      if (refill_vld) got_ids.push_back(int'(refill_id));
      cyc();
    end
    mem_resp_vld = 1'b0; refill_rdy = 1'b0;
    check("t4 refill count", 32'(got_ids.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      check("t4 refill order", (k < got_ids.size()) ? 32'(got_ids[k]) : 32'hffffffff,
            32'(order[k]));

    // 5. back-pressure with entries 1 and 3 in REQ
    v_free_rdy = 4'b1010; cyc(); v_free_rdy = '0;
    miss(2'd1, 26'h400); cyc();
    miss(2'd3, 26'h500); cyc(); no_miss();
    for (int k = 0; k < 5; k++) begin
      check("t5 stalled id", 32'(mem_req_id), 32'd1);
      check("t5 stalled addr", 32'(mem_req_addr), 32'h400);
      cyc();
    end
    mem_req_rdy = 1'b1; #1;
    check("t5 first issue", 32'(mem_req_id), 32'd1);
    cyc();
    check("t5 second issue", 32'(mem_req_id), 32'd3);
    check("t5 second addr", 32'(mem_req_addr), 32'h500);
    cyc(); mem_req_rdy = 1'b0;
    check("t5 drained", 32'(mem_req_vld), 32'd0);
    refill_rdy = 1'b1;
    mem_resp_vld = 1'b1; mem_resp_id = 2'd3; cyc();
    mem_resp_id = 2'd1; cyc();
    mem_resp_vld = 1'b0; repeat (2) cyc();
    refill_rdy = 1'b0;

    // 6. reset with entries in DONE, WAIT and REQ
    v_free_rdy = 4'b0111; cyc(); v_free_rdy = '0;
    miss(2'd0, 26'h600); cyc();
    miss(2'd1, 26'h700); mem_req_rdy = 1'b1; cyc();
    miss(2'd2, 26'h800); cyc();
    no_miss(); mem_req_rdy = 1'b0; mem_resp_vld = 1'b1; mem_resp_id = 2'd0; cyc();
    mem_resp_vld = 1'b0;
    check("t6 busy before rst", 32'(mshr_busy_num), 32'd3);
    check("t6 refill before rst", 32'(refill_vld), 32'd1);
    check("t6 req before rst", 32'(mem_req_id), 32'd2);
    rst = 1'b1; cyc();
    check("t6 free after rst", 32'(v_free_vld), 32'h0000000f);
    check("t6 busy after rst", 32'(mshr_busy_num), 32'd0);
    check("t6 req after rst", 32'(mem_req_vld), 32'd0);
    check("t6 refill after rst", 32'(refill_vld), 32'd0);
    rst = 1'b0; mem_resp_vld = 1'b1; mem_resp_id = 2'd1; cyc(); mem_resp_vld = 1'b0;
    check("t6 stray resp refill", 32'(refill_vld), 32'd0);
    check("t6 stray resp busy", 32'(mshr_busy_num), 32'd0);
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
